// File: rtl/fp_pkg.sv
// -----------------------------------------------------------------------------
// fp_pkg: shared definitions for the pipelined floating-point adder.
//   - default exponent/mantissa widths
//   - operand class encoding carried down the pipeline for special-case handling
//   - GRS_W: number of guard/round/sticky bits appended below the mantissa
//   - helpers: generic field extraction, operand classification, canonical NaN
// Helpers work on 64-bit containers, so formats up to 64 bits wide are covered.
// -----------------------------------------------------------------------------
package fp_pkg;

    localparam int EXP_W_DEF = 8;
    localparam int MAN_W_DEF = 23;
    localparam int GRS_W     = 3;

    typedef enum logic [2:0] {
        CLS_ZERO,
        CLS_NORM,
        CLS_SUB,
        CLS_INF,
        CLS_NAN
    } fp_class_e;

    // Extract 'width' bits starting at bit 'lsb' of a packed word.
    function automatic logic [63:0] fp_field(input logic [63:0] word, input int lsb, input int width);
        return (word >> lsb) & ~({64{1'b1}} << width);
    endfunction

    function automatic fp_class_e fp_classify(input logic exp_ones, input logic exp_zero,
                                              input logic frac_zero);
        if (exp_ones) return frac_zero ? CLS_INF : CLS_NAN;
        if (exp_zero) return frac_zero ? CLS_ZERO : CLS_SUB;
        return CLS_NORM;
    endfunction

    // Canonical NaN: sign 0, exponent all ones, fraction MSB = qnan_msb.
    // With qnan_msb = 0 the fraction LSB is set so the word is still a NaN.
    function automatic logic [63:0] fp_canon_nan(input int exp_w, input int man_w, input logic qnan_msb);
        logic [63:0] r;
        r = (~({64{1'b1}} << exp_w)) << man_w;
        if (qnan_msb) r = r | (64'd1 << (man_w - 1));
        else          r = r | 64'd1;
        return r;
    endfunction

endpackage

// File: rtl/fp_add_pipe_if.sv
// -----------------------------------------------------------------------------
// fp_add_pipe_if: operand/result bus of the FP adder.
//   in_valid/in_ready  : operand handshake (a, b, op: 0 = a+b, 1 = a-b)
//   out_valid/out_ready: result handshake (s plus ovf/inv/inx flags)
// master = producer/consumer side, slave = the adder.
// -----------------------------------------------------------------------------
interface fp_add_pipe_if
    import fp_pkg::*;
#(
    parameter int EXP_W = EXP_W_DEF,
    parameter int MAN_W = MAN_W_DEF
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] s;
    logic         flag_ovf;
    logic         flag_inv;
    logic         flag_inx;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, s, flag_ovf, flag_inv, flag_inx
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, s, flag_ovf, flag_inv, flag_inx
    );
endinterface

// File: rtl/fp_lzc.sv
// -----------------------------------------------------------------------------
// fp_lzc: combinational leading-zero counter.
//   din : vector to scan (MSB first)
//   cnt : number of zeros above the first one; W when din is all zero
// -----------------------------------------------------------------------------
module fp_lzc
    import fp_pkg::*;
#(
    parameter int W     = 27,
    parameter int CNT_W = $clog2(W + 1)
) (
    input  logic [W-1:0]     din,
    output logic [CNT_W-1:0] cnt
);
    // One-hot marker of the most significant set bit.
    logic [W-1:0] lead;

    for (genvar gi = 0; gi < W; gi++) begin : g_lead
        if (gi == W - 1) begin : g_top
            assign lead[gi] = din[gi];
        end else begin : g_low
            assign lead[gi] = din[gi] & ~(|din[W-1:gi+1]);
        end
    end

    always_comb begin
        cnt = CNT_W'(W);
        for (int i = 0; i < W; i++) begin
            if (lead[i]) cnt = CNT_W'(W - 1 - i);
        end
    end
endmodule

// File: rtl/fp_add_pipe.sv
// -----------------------------------------------------------------------------
// fp_add_pipe: 3-stage pipelined floating-point adder/subtractor, RNE rounding,
// subnormal support, ovf/inv/inx flags.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : operand/result handshake (fp_add_pipe_if.slave)
// Stages: 1 align (swap, classify, shift with sticky), 2 add/sub magnitudes,
// 3 normalise, round, apply special-case overrides. A stage loads when the
// stage after it is empty or moving, so a full pipe streams one result/cycle.
// -----------------------------------------------------------------------------
module fp_add_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W    = EXP_W_DEF,
    parameter int MAN_W    = MAN_W_DEF,
    parameter bit QNAN_MSB = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    fp_add_pipe_if.slave bus
);
    localparam int W     = 1 + EXP_W + MAN_W;
    localparam int MX_W  = MAN_W + 1 + GRS_W;   // hidden + fraction + GRS
    localparam int SUM_W = MX_W + 1;            // plus carry
    localparam int LZ_W  = $clog2(MX_W + 1);
    localparam int SH_W  = ((EXP_W > LZ_W) ? EXP_W : LZ_W) + 1;
    localparam logic [EXP_W-1:0] EXP_ONES  = '1;
    localparam logic [W-1:0]     CANON_NAN = W'(fp_canon_nan(EXP_W, MAN_W, QNAN_MSB));

    typedef struct packed {
        logic             sx;
        logic             eff_sub;
        logic [EXP_W-1:0] ex;
        logic [MX_W-1:0]  mx;
        logic [MX_W-1:0]  my;
        fp_class_e        cx;
        fp_class_e        cy;
    } s1_t;

    typedef struct packed {
        logic             sx;
        logic             eff_sub;
        logic [EXP_W-1:0] ex;
        logic [SUM_W-1:0] sum;
        fp_class_e        cx;
        fp_class_e        cy;
    } s2_t;

    typedef struct packed {
        logic [W-1:0] s;
        logic         ovf;
        logic         inv;
        logic         inx;
    } s3_t;

    logic v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    s1_t  s1_q, s1_d;
    s2_t  s2_q, s2_d;
    s3_t  s3_q, s3_d;
    logic en1, en2, en3;

    assign en3 = !v3_q || bus.out_ready;
    assign en2 = !v2_q || en3;
    assign en1 = !v1_q || en2;

    assign bus.in_ready  = en1;
    assign bus.out_valid = v3_q;
    assign bus.s         = s3_q.s;
    assign bus.flag_ovf  = s3_q.ovf;
    assign bus.flag_inv  = s3_q.inv;
    assign bus.flag_inx  = s3_q.inx;

    // ---------------- stage 1: align ----------------
    logic [W-1:0]     b_eff, x_w, y_w;
    logic             a_big, hx, hy, lost;
    logic [EXP_W-1:0] ex_raw, ey_raw, ex_eff, ey_eff, d;
    logic [MAN_W-1:0] fx, fy;
    logic [MX_W-1:0]  my_full, my_sh;

    always_comb begin
        b_eff   = {bus.b[W-1] ^ bus.op, bus.b[W-2:0]};
        // Magnitude compare on the packed exp:fraction field orders by exp, then fraction.
        a_big   = bus.a[W-2:0] >= b_eff[W-2:0];
        x_w     = a_big ? bus.a : b_eff;
        y_w     = a_big ? b_eff : bus.a;
        ex_raw  = EXP_W'(fp_field(64'(x_w), MAN_W, EXP_W));
        ey_raw  = EXP_W'(fp_field(64'(y_w), MAN_W, EXP_W));
        fx      = MAN_W'(fp_field(64'(x_w), 0, MAN_W));
        fy      = MAN_W'(fp_field(64'(y_w), 0, MAN_W));
        hx      = |ex_raw;
        hy      = |ey_raw;
        ex_eff  = hx ? ex_raw : EXP_W'(1);
        ey_eff  = hy ? ey_raw : EXP_W'(1);
        d       = ex_eff - ey_eff;
        my_full = {hy, fy, GRS_W'(0)};
        // Barrel shift right; everything shifted out is folded into sticky.
        // Once d >= MX_W-1 the whole mantissa lands in (or below) the sticky bit.
        my_sh   = my_full >> d;
        lost    = |(my_full & ~({MX_W{1'b1}} << d));

        v1_d = v1_q;
        s1_d = s1_q;
        if (en1) begin
            v1_d         = bus.in_valid;
            s1_d.sx      = x_w[W-1];
            s1_d.eff_sub = x_w[W-1] ^ y_w[W-1];
            s1_d.ex      = ex_eff;
            s1_d.mx      = {hx, fx, GRS_W'(0)};
            s1_d.my      = {my_sh[MX_W-1:1], my_sh[0] | lost};
            s1_d.cx      = fp_classify(&ex_raw, ~|ex_raw, ~|fx);
            s1_d.cy      = fp_classify(&ey_raw, ~|ey_raw, ~|fy);
        end
    end

    // ---------------- stage 2: add ----------------
    always_comb begin
        v2_d = v2_q;
        s2_d = s2_q;
        if (en2) begin
            v2_d         = v1_q;
            s2_d.sx      = s1_q.sx;
            s2_d.eff_sub = s1_q.eff_sub;
            s2_d.ex      = s1_q.ex;
            s2_d.cx      = s1_q.cx;
            s2_d.cy      = s1_q.cy;
            // X has the larger magnitude, so the difference is never negative.
            s2_d.sum     = s1_q.eff_sub ? ({1'b0, s1_q.mx} - {1'b0, s1_q.my})
                                        : ({1'b0, s1_q.mx} + {1'b0, s1_q.my});
        end
    end

    // ---------------- stage 3: normalise / round ----------------
    logic [LZ_W-1:0]    lz;
    logic [SH_W-1:0]    lz_ext, lim, shamt;
    logic [MX_W-1:0]    norm;
    logic [EXP_W:0]     exp_n, exp_f;
    logic [MAN_W+1:0]   mant_r;
    logic               g, r, st, inc, sign_r;
    s3_t                res;

    fp_lzc #(.W(MX_W), .CNT_W(LZ_W)) u_lzc (
        .din (s2_q.sum[MX_W-1:0]),
        .cnt (lz)
    );

    always_comb begin
        lz_ext = SH_W'(lz);
        // Never normalise below exponent 1; what remains unnormalised is subnormal.
        lim    = SH_W'(s2_q.ex) - SH_W'(1);
        shamt  = (lz_ext < lim) ? lz_ext : lim;
        if (s2_q.sum[SUM_W-1]) begin
            norm  = {s2_q.sum[SUM_W-1:2], s2_q.sum[1] | s2_q.sum[0]};
            exp_n = {1'b0, s2_q.ex} + (EXP_W+1)'(1);
        end else begin
            norm  = s2_q.sum[MX_W-1:0] << shamt;
            exp_n = {1'b0, s2_q.ex} - (EXP_W+1)'(shamt);
        end
        g      = norm[2];
        r      = norm[1];
        st     = norm[0];
        inc    = g & (r | st | norm[3]);
        mant_r = {1'b0, norm[MX_W-1:GRS_W]} + (MAN_W+2)'(inc);
        // Rounding carry-out renormalises; a missing hidden bit means subnormal
        // (this also promotes a subnormal that rounds up into the normal range).
        if (mant_r[MAN_W+1])   exp_f = exp_n + (EXP_W+1)'(1);
        else if (mant_r[MAN_W]) exp_f = exp_n;
        else                    exp_f = '0;

        sign_r = s2_q.sx;
        if (s2_q.eff_sub && (s2_q.sum == '0)) sign_r = 1'b0;

        res.s   = {sign_r, exp_f[EXP_W-1:0], mant_r[MAN_W-1:0]};
        res.ovf = 1'b0;
        res.inv = 1'b0;
        res.inx = g | r | st;
        if (exp_f >= {1'b0, EXP_ONES}) begin
            res.s   = {sign_r, EXP_ONES, MAN_W'(0)};
            res.ovf = 1'b1;
            res.inx = 1'b1;
        end

        // Specials. An infinite operand always ends up as X because it
        // out-ranks every finite magnitude.
        if (s2_q.cx == CLS_NAN || s2_q.cy == CLS_NAN) begin
            res = '{s: CANON_NAN, ovf: 1'b0, inv: 1'b0, inx: 1'b0};
        end else if (s2_q.cx == CLS_INF) begin
            if (s2_q.cy == CLS_INF && s2_q.eff_sub)
                res = '{s: CANON_NAN, ovf: 1'b0, inv: 1'b1, inx: 1'b0};
            else
                res = '{s: {s2_q.sx, EXP_ONES, MAN_W'(0)}, ovf: 1'b0, inv: 1'b0, inx: 1'b0};
        end

        v3_d = v3_q;
        s3_d = s3_q;
        if (en3) begin
            v3_d = v2_q;
            if (v2_q) s3_d = res;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else begin
            v1_q <= v1_d;
            v2_q <= v2_d;
            v3_q <= v3_d;
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end
endmodule

// File: tb/tb_fp_add_pipe.sv
// -----------------------------------------------------------------------------
// tb_fp_add_pipe: directed self-checking bench for fp_add_pipe (single precision).
// Directed vectors with hand-computed results, a backpressured stream of eight
// operations and a reset asserted while the pipeline is full.
// -----------------------------------------------------------------------------
module tb_fp_add_pipe;
    import fp_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    fp_add_pipe_if #(.EXP_W(8), .MAN_W(23)) bus ();

    fp_add_pipe #(.EXP_W(8), .MAN_W(23), .QNAN_MSB(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One operation through an empty pipe; checks latency, result and flags.
    task automatic run_one(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic op, input logic [31:0] exp_s, input logic [2:0] exp_f);
        int lat;
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        bus.a        = a;
        bus.b        = b;
        bus.op       = op;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        $display("txn %s: a=%h b=%h op=%0d -> s=%h ovf/inv/inx=%b lat=%0d",
                 tag, a, b, op, bus.s, {bus.flag_ovf, bus.flag_inv, bus.flag_inx}, lat);
        chk_eq({tag, "_lat"}, lat, 3);
        chk_eq({tag, "_s"}, bus.s, exp_s);
        chk_eq({tag, "_flags"}, {bus.flag_ovf, bus.flag_inv, bus.flag_inx}, exp_f);
    endtask

    logic [31:0] stream_b   [8] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                                    32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
    logic [31:0] stream_exp [8] = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000,
                                    32'h40C00000, 32'h40E00000, 32'h41000000, 32'h41100000};

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.op        = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_eq("rst_out_valid", bus.out_valid, 0);
        chk_eq("rst_s", bus.s, 0);
        chk_eq("rst_flags", {bus.flag_ovf, bus.flag_inv, bus.flag_inx}, 0);
        chk_eq("rst_in_ready", bus.in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;

        run_one("one_plus_two", 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 3'b000);
        run_one("one_minus_one", 32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 3'b000);
        run_one("negz_minus_z", 32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 3'b000);
        run_one("tie_even", 32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 3'b001);
        run_one("above_tie", 32'h3F800000, 32'h33800001, 1'b0, 32'h3F800001, 3'b001);
        run_one("tie_odd_up", 32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 3'b001);
        run_one("overflow", 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b101);
        run_one("inf_minus_inf", 32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 3'b010);
        run_one("nan_in", 32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b000);
        run_one("neginf_plus_one", 32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 3'b000);
        run_one("sub_plus_sub", 32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 3'b000);
        run_one("min_norm_minus", 32'h00800000, 32'h00000001, 1'b1, 32'h007FFFFF, 3'b000);
        run_one("cancel", 32'h40400000, 32'h40000000, 1'b1, 32'h3F800000, 3'b000);
        run_one("neg_plus_pos", 32'hBF800000, 32'h40000000, 1'b0, 32'h3F800000, 3'b000);

        // Streaming with backpressure pattern 1,0,0,1 repeating.
        @(posedge clk); #1;
        fork
            begin : producer
                for (int i = 0; i < 8; i++) begin
                    int guard;
                    bus.in_valid = 1'b1;
                    bus.a        = 32'h3F800000;
                    bus.b        = stream_b[i];
                    bus.op       = 1'b0;
                    guard        = 0;
                    do begin
                        @(negedge clk);
                        guard++;
                    end while (!bus.in_ready && guard < 100);
                    @(posedge clk); #1;
                end
                bus.in_valid = 1'b0;
            end
            begin : consumer
                logic [3:0]  pat;
                logic        held;
                logic [31:0] held_s;
                int          k;
                pat  = 4'b1001;
                held = 1'b0;
                held_s = '0;
                k    = 0;
                for (int cyc = 0; cyc < 200 && k < 8; cyc++) begin
                    @(posedge clk); #1;
                    bus.out_ready = pat[cyc % 4];
                    @(negedge clk);
                    if (held) begin
                        chk_eq("hold_valid", bus.out_valid, 1);
                        chk_eq("hold_s", bus.s, held_s);
                    end
                    if (bus.out_valid && bus.out_ready) begin
                        $display("txn stream%0d: s=%h", k, bus.s);
                        chk_eq($sformatf("stream%0d", k), bus.s, stream_exp[k]);
                        k++;
                        held = 1'b0;
                    end else begin
                        held   = bus.out_valid;
                        held_s = bus.s;
                    end
                end
                chk_eq("stream_count", k, 8);
            end
        join

        begin
            int extra;
            extra = 0;
            @(posedge clk); #1;
            bus.out_ready = 1'b1;
            repeat (5) begin
                @(negedge clk);
                if (bus.out_valid) extra++;
            end
            chk_eq("stream_no_extra", extra, 0);
        end

        // Fill the pipe while stalled, then reset asynchronously.
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.a         = 32'h3F800000;
        bus.b         = 32'h3F800000;
        bus.op        = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk_eq("pre_rst_valid", bus.out_valid, 1);
        chk_eq("pre_rst_s", bus.s, 32'h40000000);
        #1;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        $display("txn mid_reset: out_valid=%0d s=%h", bus.out_valid, bus.s);
        chk_eq("mid_rst_valid", bus.out_valid, 0);
        chk_eq("mid_rst_s", bus.s, 0);
        chk_eq("mid_rst_in_ready", bus.in_ready, 1);
        @(negedge clk);
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        begin
            int seen;
            seen = 0;
            repeat (6) begin
                @(negedge clk);
                if (bus.out_valid) seen++;
            end
            chk_eq("post_rst_no_output", seen, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/fp_add_pipe.md
Name: fp_add_pipe

Overview:
- Parametrised, fully pipelined IEEE-754-style floating-point adder/subtractor with a valid/ready handshake.
- Generic exponent/mantissa widths, selectable add/sub per operation, round-to-nearest-even, subnormal support and exception flags.
- Three register stages: align, add, normalise/round.
- Sits in the arithmetic datapath as the drop-in FP add unit; one result per cycle when not stalled.

Parameters:
- EXP_W, 8, exponent field width.
- MAN_W, 23, stored mantissa (fraction) width; word width W = 1+EXP_W+MAN_W.
- QNAN_MSB, 1, when 1 the canonical NaN output has fraction MSB set (quiet NaN).

Ports:
- clk  input  1  clock, all state rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand pair present.
- in_ready  output  1  stage 1 can accept this cycle.
- a  input  W  operand A.
- b  input  W  operand B.
- op  input  1  0 = A+B, 1 = A-B (B sign inverted before compare).
- out_valid  output  1  result present.
- out_ready  input  1  downstream accepts result.
- s  output  W  result.
- flag_ovf  output  1  overflow to infinity (valid with s).
- flag_inv  output  1  invalid operation (valid with s).
- flag_inx  output  1  inexact: a rounded-off bit was nonzero (valid with s).

Behaviour:
- Reset (async assert, sync-to-clk release): all stage valid bits 0; out_valid=0; s=0; all flags 0; in_ready=1.
- Handshake:
  - Transfer on in_valid&&in_ready.
  - Output is held stable while out_valid&&!out_ready.
  - in_ready = !v1 || (advance into stage 2 possible): a stage advances when the next stage is empty or itself advancing.
  - No bubbles when out_ready=1.
  - Latency: exactly 3 cycles from input transfer to out_valid.
- Stage 1 (align):
  - Apply op to sign of B.
  - Swap so X has the larger magnitude (exp, then fraction).
  - Hidden bit = |exp; effective exponent = max(exp,1).
  - d = eX-eY.
  - Right-shift Y mantissa extended with 3 extra bits (guard, round, sticky).
  - Sticky ORs every bit shifted out.
  - If d >= MAN_W+3, Y becomes sticky-only.
  - Classify specials here and carry their class forward.
- Stage 2 (add):
  - Same signs: add magnitudes (MAN_W+5 bits incl. carry).
  - Different signs: subtract Y from X (never negative after swap).
  - Result sign = sign of X.
- Stage 3 (normalise/round):
  - Carry out: shift right 1, exp+1, sticky absorbs the dropped bit.
  - Otherwise: leading-zero count, left shift limited so exponent does not drop below 1; exponent 1 with hidden bit 0 gives a subnormal (exp field 0).
  - RNE rounding: increment if G && (R||S||LSB).
  - Mantissa overflow from rounding renormalises with exp+1.
  - Exp field reaching all-ones gives ±inf, flag_ovf=1, flag_inx=1.
- Specials (override stage 3):
  - Any NaN input: canonical NaN (sign 0, exp all-ones, fraction MSB=QNAN_MSB, rest 0 except nonzero if QNAN_MSB=0).
  - inf + (-inf) after op: canonical NaN, flag_inv=1.
  - inf with finite: that inf.
  - Exact zero result with opposite signs: +0. (-0)+(-0) = -0.
- Reset mid-operation: all in-flight results are discarded; no partial output afterwards.

Decomposition:
- Shared package fp_pkg holds:
  - default EXP_W/MAN_W;
  - class encoding (ZERO, NORM, SUB, INF, NAN);
  - GRS width constant;
  - functions for field extraction and the canonical-NaN constant.
- Sub-module fp_lzc (parametrised leading-zero counter) is used by stage 3.
- Alignment and normalise shifts are barrel shifters.

Test Plan (single precision defaults):
- a=0x3F800000, b=0x40000000, op=0 -> s=0x40400000, no flags, out_valid exactly 3 cycles later.
- a=0x3F800000, b=0x3F800000, op=1 -> s=0x00000000 (+0). Then a=0x80000000, b=0x00000000, op=1 -> s=0x80000000.
- Ties and inexact:
  - a=0x3F800000, b=0x33800000, op=0 (tie) -> s=0x3F800000, flag_inx=1.
  - b=0x33800001 -> s=0x3F800001, flag_inx=1.
- Exceptions:
  - a=0x7F7FFFFF, b=0x7F7FFFFF, op=0 -> s=0x7F800000, flag_ovf=1.
  - a=0x7F800000, b=0x7F800000, op=1 -> s=0x7FC00000, flag_inv=1.
- Subnormals: a=0x00000001, b=0x00000001, op=0 -> s=0x00000002. Then a=0x00800000, b=0x00000001, op=1 -> s=0x007FFFFF.
- Streaming with backpressure: 8 back-to-back ops with out_ready toggled 1,0,0,1,... -> results in order, none lost or duplicated, s stable while stalled. Assert rst_n mid-stream -> out_valid=0 immediately.
